// File: rtl/i2c_arbiter.sv
// Two-requester round-robin arbiter in front of a single i2c_dri command port.
// Latency: i2c_exec rises 2 cycles after a request is sampled while idle; done pulses 1 cycle after i2c_done.
// Backpressure: one outstanding command per requester; repeat requests while pending are dropped.
// Optional I2C_ARB_TIMEOUT_EN: abort a WAIT that lasts TIMEOUT_CYC cycles.
module i2c_arbiter #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_exec,
    input  logic        req0_bit_ctrl,
    input  logic        req0_rh_wl,
    input  logic [15:0] req0_addr,
    input  logic [7:0]  req0_data_w,
    output logic        req0_done,
    output logic        req0_ack,
    output logic [7:0]  req0_data_r,

    input  logic        req1_exec,
    input  logic        req1_bit_ctrl,
    input  logic        req1_rh_wl,
    input  logic [15:0] req1_addr,
    input  logic [7:0]  req1_data_w,
    output logic        req1_done,
    output logic        req1_ack,
    output logic [7:0]  req1_data_r,

    output logic        i2c_exec,
    output logic        i2c_bit_ctrl,
    output logic        i2c_rh_wl,
    output logic [15:0] i2c_addr,
    output logic [7:0]  i2c_data_w,
    input  logic        i2c_done,
    input  logic        i2c_ack,
    input  logic [7:0]  i2c_data_r,

    output logic        busy,
    output logic        grant
);

    typedef struct packed {
        logic        bit_ctrl;
        logic        rh_wl;
        logic [15:0] addr;
        logic [7:0]  data_w;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] pend;
    logic       last_grant;
    cmd_t       cmd0;
    cmd_t       cmd1;
    cmd_t       cmd_sel;
    logic       sel;
    logic       tmo_hit;
    logic       fin;
    logic [1:0] clr;

`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    // Real completion takes precedence over a coincident timeout.
    assign tmo_hit = (state == WAIT) && !i2c_done && (tmo_cnt == TIMEOUT_CYC - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= 16'd0;
        end else if ((state == WAIT) && !fin) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end else begin
            tmo_cnt <= 16'd0;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign fin     = (state == WAIT) && (i2c_done || tmo_hit);
    assign clr     = {fin && grant, fin && !grant};
    // Both pending: serve the one that was not served last.
    assign sel     = (pend[0] && pend[1]) ? ~last_grant : pend[1];
    assign cmd_sel = sel ? cmd1 : cmd0;

    // Request capture; a new request on the clearing cycle re-arms the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 2'b00;
            cmd0 <= '0;
            cmd1 <= '0;
        end else begin
            if (req0_exec && (!pend[0] || clr[0])) begin
                pend[0] <= 1'b1;
                cmd0    <= '{bit_ctrl: req0_bit_ctrl, rh_wl: req0_rh_wl,
                             addr: req0_addr, data_w: req0_data_w};
            end else if (clr[0]) begin
                pend[0] <= 1'b0;
            end
            if (req1_exec && (!pend[1] || clr[1])) begin
                pend[1] <= 1'b1;
                cmd1    <= '{bit_ctrl: req1_bit_ctrl, rh_wl: req1_rh_wl,
                             addr: req1_addr, data_w: req1_data_w};
            end else if (clr[1]) begin
                pend[1] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            grant        <= 1'b0;
            busy         <= 1'b0;
            i2c_exec     <= 1'b0;
            i2c_bit_ctrl <= 1'b0;
            i2c_rh_wl    <= 1'b0;
            i2c_addr     <= 16'h0000;
            i2c_data_w   <= 8'h00;
            req0_done    <= 1'b0;
            req0_ack     <= 1'b0;
            req0_data_r  <= 8'h00;
            req1_done    <= 1'b0;
            req1_ack     <= 1'b0;
            req1_data_r  <= 8'h00;
        end else begin
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            i2c_exec  <= 1'b0;
            case (state)
                IDLE: begin
                    if (|pend) begin
                        state        <= ISSUE;
                        busy         <= 1'b1;
                        grant        <= sel;
                        i2c_bit_ctrl <= cmd_sel.bit_ctrl;
                        i2c_rh_wl    <= cmd_sel.rh_wl;
                        i2c_addr     <= cmd_sel.addr;
                        i2c_data_w   <= cmd_sel.data_w;
                    end
                end
                ISSUE: begin
                    i2c_exec <= 1'b1;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (fin) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        last_grant <= grant;
                        if (grant) begin
                            req1_done   <= 1'b1;
                            req1_ack    <= i2c_ack | tmo_hit;
                            req1_data_r <= tmo_hit ? 8'h00 : i2c_data_r;
                        end else begin
                            req0_done   <= 1'b1;
                            req0_ack    <= i2c_ack | tmo_hit;
                            req0_data_r <= tmo_hit ? 8'h00 : i2c_data_r;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: the bench plays i2c_dri and both requesters.
module tb_i2c_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_exec, req0_bit_ctrl, req0_rh_wl;
    logic [15:0] req0_addr;
    logic [7:0]  req0_data_w;
    logic        req0_done, req0_ack;
    logic [7:0]  req0_data_r;
    logic        req1_exec, req1_bit_ctrl, req1_rh_wl;
    logic [15:0] req1_addr;
    logic [7:0]  req1_data_w;
    logic        req1_done, req1_ack;
    logic [7:0]  req1_data_r;
    logic        i2c_exec, i2c_bit_ctrl, i2c_rh_wl;
    logic [15:0] i2c_addr;
    logic [7:0]  i2c_data_w;
    logic        i2c_done, i2c_ack;
    logic [7:0]  i2c_data_r;
    logic        busy, grant;

    int n_chk  = 0;
    int n_pass = 0;
    int d0_cnt = 0;
    int d1_cnt = 0;

    always #5 clk = ~clk;

    i2c_arbiter #(.TIMEOUT_CYC(16'd100)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_exec(req0_exec), .req0_bit_ctrl(req0_bit_ctrl), .req0_rh_wl(req0_rh_wl),
        .req0_addr(req0_addr), .req0_data_w(req0_data_w), .req0_done(req0_done),
        .req0_ack(req0_ack), .req0_data_r(req0_data_r),
        .req1_exec(req1_exec), .req1_bit_ctrl(req1_bit_ctrl), .req1_rh_wl(req1_rh_wl),
        .req1_addr(req1_addr), .req1_data_w(req1_data_w), .req1_done(req1_done),
        .req1_ack(req1_ack), .req1_data_r(req1_data_r),
        .i2c_exec(i2c_exec), .i2c_bit_ctrl(i2c_bit_ctrl), .i2c_rh_wl(i2c_rh_wl),
        .i2c_addr(i2c_addr), .i2c_data_w(i2c_data_w), .i2c_done(i2c_done),
        .i2c_ack(i2c_ack), .i2c_data_r(i2c_data_r),
        .busy(busy), .grant(grant)
    );

    always @(negedge clk) begin
        if (req0_done) d0_cnt++;
        if (req1_done) d1_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_exec(input string tag);
        int n = 0;
        while (!i2c_exec && n < 20) begin
            step();
            n++;
        end
        chk(tag, i2c_exec, 1);
    endtask

    task automatic finish_txn(input logic ack, input logic [7:0] data);
        i2c_done   = 1'b1;
        i2c_ack    = ack;
        i2c_data_r = data;
        step();
        i2c_done   = 1'b0;
    endtask

    task automatic req0(input logic bc, input logic rw, input logic [15:0] a, input logic [7:0] d);
        req0_exec = 1'b1; req0_bit_ctrl = bc; req0_rh_wl = rw; req0_addr = a; req0_data_w = d;
    endtask

    task automatic req1(input logic bc, input logic rw, input logic [15:0] a, input logic [7:0] d);
        req1_exec = 1'b1; req1_bit_ctrl = bc; req1_rh_wl = rw; req1_addr = a; req1_data_w = d;
    endtask

    initial begin
        int s0, s1;
        rst_n = 1'b0;
        req0_exec = 0; req0_bit_ctrl = 0; req0_rh_wl = 0; req0_addr = 0; req0_data_w = 0;
        req1_exec = 0; req1_bit_ctrl = 0; req1_rh_wl = 0; req1_addr = 0; req1_data_w = 0;
        i2c_done = 0; i2c_ack = 0; i2c_data_r = 0;
        step();
        chk("rst_busy", busy, 0);
        chk("rst_exec", i2c_exec, 0);
        chk("rst_grant", grant, 0);
        chk("rst_done", {req0_done, req1_done}, 0);
        rst_n = 1'b1;
        step();

        // Single write from requester 0, exact 2-cycle issue latency.
        req0(0, 0, 16'h0002, 8'h45);
        step();
        req0_exec = 0;
        chk("lat_c0_exec", i2c_exec, 0);
        step();
        chk("lat_c1_exec", i2c_exec, 0);
        chk("lat_c1_busy", busy, 1);
        step();
        chk("lat_c2_exec", i2c_exec, 1);
        chk("t1_addr", i2c_addr, 16'h0002);
        chk("t1_data", i2c_data_w, 8'h45);
        chk("t1_rw", {i2c_bit_ctrl, i2c_rh_wl}, 2'b00);
        chk("t1_grant", grant, 0);
        step();
        chk("t1_exec_1cyc", i2c_exec, 0);
        finish_txn(0, 8'h00);
        chk("t1_done", req0_done, 1);
        chk("t1_ack", req0_ack, 0);
        chk("t1_busy", busy, 0);
        step();
        chk("t1_done_pulse", req0_done, 0);

        // Simultaneous requests after reset: requester 0 first, then 1.
        do_reset();
        s0 = d0_cnt; s1 = d1_cnt;
        req0(0, 0, 16'h0010, 8'h11);
        req1(1, 1, 16'h0003, 8'h00);
        step();
        req0_exec = 0; req1_exec = 0;
        wait_exec("t2_exec_a");
        chk("t2_addr_a", i2c_addr, 16'h0010);
        chk("t2_grant_a", grant, 0);
        finish_txn(0, 8'h00);
        chk("t2_done_a", {req1_done, req0_done}, 2'b01);
        wait_exec("t2_exec_b");
        chk("t2_addr_b", i2c_addr, 16'h0003);
        chk("t2_rw_b", {i2c_bit_ctrl, i2c_rh_wl}, 2'b11);
        chk("t2_grant_b", grant, 1);
        finish_txn(1, 8'h59);
        chk("t2_done_b", {req1_done, req0_done}, 2'b10);
        chk("t2_data_r", req1_data_r, 8'h59);
        chk("t2_ack1", req1_ack, 1);
        step(); step(); step();
        chk("t2_ack0_hold", req0_ack, 0);
        chk("t2_cnt0", d0_cnt - s0, 1);
        chk("t2_cnt1", d1_cnt - s1, 1);

        // Repeat request while pending is dropped.
        s1 = d1_cnt;
        req1(0, 1, 16'h0020, 8'h00);
        step();
        req1(0, 1, 16'h0077, 8'h00);
        step();
        req1_exec = 0;
        wait_exec("t3_exec");
        chk("t3_addr", i2c_addr, 16'h0020);
        finish_txn(0, 8'h33);
        repeat (6) step();
        chk("t3_idle", busy, 0);
        chk("t3_cnt1", d1_cnt - s1, 1);

        // New request on the same cycle its slot is cleared.
        s0 = d0_cnt;
        req0(0, 0, 16'h0030, 8'hA5);
        step();
        req0_exec = 0;
        wait_exec("t4_exec_a");
        chk("t4_addr_a", i2c_addr, 16'h0030);
        req0(0, 0, 16'h0031, 8'h5A);
        finish_txn(0, 8'h00);
        req0_exec = 0;
        chk("t4_done_a", req0_done, 1);
        wait_exec("t4_exec_b");
        chk("t4_addr_b", i2c_addr, 16'h0031);
        chk("t4_data_b", i2c_data_w, 8'h5A);
        finish_txn(0, 8'h00);
        step();
        chk("t4_cnt0", d0_cnt - s0, 2);

        // Reset while waiting: everything cleared, no done.
        req1(0, 0, 16'h0040, 8'h01);
        step();
        req1_exec = 0;
        wait_exec("t5_exec");
        step();
        s0 = d0_cnt; s1 = d1_cnt;
        rst_n = 1'b0;
        i2c_done = 1'b1;
        #1;
        chk("t5_rst_out", {busy, i2c_exec, grant, req1_ack, i2c_addr}, 0);
        step();
        i2c_done = 1'b0;
        rst_n = 1'b1;
        repeat (4) step();
        chk("t5_no_done", (d0_cnt - s0) + (d1_cnt - s1), 0);
        chk("t5_idle", busy, 0);
        // Stray i2c_done while idle is ignored.
        finish_txn(0, 8'hFF);
        chk("t5_stray", {req0_done, req1_done, busy}, 0);
        req1(0, 0, 16'h0041, 8'h02);
        step();
        req1_exec = 0;
        wait_exec("t5_exec2");
        chk("t5_addr2", i2c_addr, 16'h0041);
        chk("t5_grant2", grant, 1);
        finish_txn(0, 8'h00);
        chk("t5_done2", {req1_done, req0_done}, 2'b10);
        step();

`ifdef I2C_ARB_TIMEOUT_EN
        begin
            int n = 0;
            req0(0, 1, 16'h0050, 8'h00);
            step();
            req0_exec = 0;
            wait_exec("t6_exec");
            while (!req0_done && n < 200) begin
                step();
                n++;
            end
            chk("t6_tmo_cyc", n, 100);
            chk("t6_tmo_ack", req0_ack, 1);
            chk("t6_tmo_data", req0_data_r, 8'h00);
            chk("t6_idle", busy, 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, 16'd50000, the number of WAIT cycles before a forced abort (used only with I2C_ARB_TIMEOUT_EN).
REQ-002 clk  in  1  module clock; i2c_dri dri_clk.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 reqN_exec  in  1  one-cycle transaction request from requester N (N=0,1).
REQ-005 reqN_bit_ctrl  in  1  word address width for requester N (0 = 8-bit, 1 = 16-bit).
REQ-006 reqN_rh_wl  in  1  read/write select for requester N (1 = read, 0 = write).
REQ-007 reqN_addr  in  16  word address for requester N.
REQ-008 reqN_data_w  in  8  write data for requester N.
REQ-009 reqN_done  out  1  one-cycle completion pulse to requester N.
REQ-010 reqN_ack  out  1  ack status of the completed transaction (0 = ack, 1 = no-ack).
REQ-011 reqN_data_r  out  8  read data of the completed transaction.
REQ-012 i2c_exec, i2c_bit_ctrl, i2c_rh_wl  out  1 each  command to i2c_dri.
REQ-013 i2c_addr  out  16, i2c_data_w  out  8  command to i2c_dri.
REQ-014 i2c_done, i2c_ack  in  1 each; i2c_data_r  in  8  result from i2c_dri.
REQ-015 busy  out  1  high in ISSUE/WAIT; grant  out  1  index of the current or last-served requester.

Function
REQ-016 A sampled reqN_exec shall set pend[N] and capture bit_ctrl/rh_wl/addr/data_w into a per-requester command register.
REQ-017 A reqN_exec arriving while pend[N]=1 shall be dropped; the captured command shall not change.
REQ-018 The FSM shall have three states: IDLE, ISSUE and WAIT.
REQ-019 IDLE -> ISSUE when any pend bit is set; selection is round-robin, with priority to the requester other than last_grant.
REQ-020 ISSUE shall assert i2c_exec for exactly one cycle, drive the selected command (held stable until leaving WAIT), and go to WAIT.
REQ-021 WAIT -> IDLE on i2c_done; the next cycle shall pulse reqN_done for the granted N, with reqN_ack/reqN_data_r registered from i2c_ack/i2c_data_r.
REQ-022 The same WAIT -> IDLE transition shall clear pend[N] and set last_grant=N.
REQ-023 reqN_ack and reqN_data_r shall hold their values until that requester's next done pulse.
REQ-024 Latency: with the FSM in IDLE and no other pending request, i2c_exec shall rise exactly 2 cycles after reqN_exec is sampled.
REQ-025 If reqN_exec is sampled in the same cycle that pend[N] is cleared, pend[N] shall be set (set wins) and the new command shall be captured.
REQ-026 Requests arriving at both ports on the same cycle shall both be captured and served back-to-back in round-robin order.
REQ-027 The non-granted requester shall never receive a done pulse.
REQ-028 i2c_done outside WAIT shall be ignored.

Reset
REQ-029 Reset shall force state=IDLE, pend=2'b00, last_grant=1 (so requester 0 wins first), all outputs to 0, and the timeout counter to 0.
REQ-030 A reset during ISSUE/WAIT shall discard all pending requests and shall emit no done pulse.

Configuration
REQ-031 With macro I2C_ARB_TIMEOUT_EN defined, a counter shall run in WAIT; on reaching TIMEOUT_CYC with no i2c_done, the FSM shall return to IDLE with reqN_done=1, reqN_ack=1 and reqN_data_r=8'h00, and pend[N] cleared.
REQ-032 Without I2C_ARB_TIMEOUT_EN, WAIT shall persist until i2c_done, no counter logic shall exist, and TIMEOUT_CYC shall be unused.

Verification
REQ-033 After reset, req0 write addr=16'h0002, data=8'h45 -> i2c_exec 2 cycles later with the same fields; model i2c_done/ack=0 -> req0_done pulse, req0_ack=0.
REQ-034 req0 and req1 exec on the same cycle (req1 read addr=16'h0003) -> req0 served first, then req1; i2c_data_r=8'h59 -> req1_data_r=8'h59, and req0 sees no second done.
REQ-035 req1 exec repeated while pending with a different addr -> original addr issued; only one req1_done.
REQ-036 req0 exec on its own done cycle -> second transaction issued; two req0_done pulses total.
REQ-037 rst_n low in WAIT -> outputs 0, no done; the next request is served normally.
REQ-038 With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYC=16'd100, no i2c_done -> req0_done at WAIT+100 with ack=1 and data_r=8'h00.
